// File: rtl/mem_xfer_pkg.sv
// Shared constants and types for the memory-to-memory transfer path
// (memory A, memory B and the transfer controller).
package mem_xfer_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int ADDR_WIDTH = 3;
    localparam int DEPTH      = 1 << ADDR_WIDTH;

    typedef logic [DATA_WIDTH-1:0] data_t;
    typedef logic [ADDR_WIDTH-1:0] addr_t;

endpackage

// File: rtl/memory_a_if.sv
// Single-port access bundle for memory A: one shared address, write strobe,
// write data and combinational read data.
interface memory_a_if #(
    parameter int DATA_WIDTH = mem_xfer_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = mem_xfer_pkg::ADDR_WIDTH
);

    logic [ADDR_WIDTH-1:0] AddrA;
    logic                  WEA;
    logic [DATA_WIDTH-1:0] DataInA;
    logic [DATA_WIDTH-1:0] DataOut;

    modport master (
        output AddrA,
        output WEA,
        output DataInA,
        input  DataOut
    );

    modport slave (
        input  AddrA,
        input  WEA,
        input  DataInA,
        output DataOut
    );

endinterface

// File: rtl/mem_word_reg.sv
// One storage word of memory A: load-enabled register cleared asynchronously
// so the whole array reads zero the moment reset is asserted.
module mem_word_reg #(
    parameter int DATA_WIDTH = mem_xfer_pkg::DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_load,
    input  logic [DATA_WIDTH-1:0] i_d,
    output logic [DATA_WIDTH-1:0] o_q
);

    logic [DATA_WIDTH-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/memory_a.sv
// Memory A: flop-based register file with one shared address port,
// synchronous write and combinational (unregistered) read.
module memory_a #(
    parameter int DATA_WIDTH = mem_xfer_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = mem_xfer_pkg::ADDR_WIDTH
) (
    input  logic       clk,
    input  logic       rst_n,
    memory_a_if.slave  mem_if
);

    import mem_xfer_pkg::*;

    localparam int MEM_DEPTH = 1 << ADDR_WIDTH;

    logic [MEM_DEPTH-1:0]  w_word_we;
    logic [DATA_WIDTH-1:0] w_mem [MEM_DEPTH];

    // One-hot write decode; the read path below never looks at WEA, so a
    // same-address write shows the old word until the capturing edge.
    always_comb begin
        w_word_we = '0;
        for (int i = 0; i < MEM_DEPTH; i++) begin
            w_word_we[i] = mem_if.WEA && (mem_if.AddrA == ADDR_WIDTH'(i));
        end
    end

    for (genvar g = 0; g < MEM_DEPTH; g++) begin : gen_word
        mem_word_reg #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_word (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_load (w_word_we[g]),
            .i_d    (mem_if.DataInA),
            .o_q    (w_mem[g])
        );
    end

    assign mem_if.DataOut = w_mem[mem_if.AddrA];

endmodule

// File: tb/tb_memory_a.sv
// Scoreboard bench for memory_a: stimulus pushes expected read words,
// a separate monitor pops and compares them against DataOut.
module tb_memory_a;

    logic clk;
    logic rst_n;

    memory_a_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) mem_if ();

    memory_a #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .mem_if (mem_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [7:0] exp;
    } exp_t;

    exp_t       exp_q[$];
    int         chk_req  = 0;
    int         n_cmp    = 0;
    int         n_fail   = 0;
    logic [7:0] model [8];
    logic [7:0] fill_v [8];

    // Monitor: every check request samples DataOut against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(chk_req);
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL %s: scoreboard empty, DataOut=0x%02h", "no_expect", mem_if.DataOut);
            end else begin
                e = exp_q.pop_front();
                if (mem_if.DataOut !== e.exp) begin
                    n_fail++;
                    $display("FAIL %s: addr=%0d DataOut=0x%02h expected=0x%02h",
                             e.name, mem_if.AddrA, mem_if.DataOut, e.exp);
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
        $fatal(1, "timeout");
    end

    task automatic expect_now(input string name, input logic [7:0] exp);
        exp_t e;
        e.name = name;
        e.exp  = exp;
        exp_q.push_back(e);
        chk_req++;
        #1;
    endtask

    task automatic write_word(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        mem_if.AddrA   = a;
        mem_if.WEA     = 1'b1;
        mem_if.DataInA = d;
        @(posedge clk);
        if (rst_n) model[a] = d;
        @(negedge clk);
        mem_if.WEA = 1'b0;
    endtask

    task automatic sweep(input string name);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            mem_if.AddrA = 3'(i);
            #1;
            expect_now(name, model[i]);
        end
    endtask

    initial begin
        fill_v[0] = 8'h23; fill_v[1] = 8'h87; fill_v[2] = 8'hB7; fill_v[3] = 8'hD7;
        fill_v[4] = 8'h11; fill_v[5] = 8'hC1; fill_v[6] = 8'h85; fill_v[7] = 8'h07;
        for (int i = 0; i < 8; i++) model[i] = 8'h00;

        rst_n          = 1'b0;
        mem_if.AddrA   = 3'd0;
        mem_if.WEA     = 1'b0;
        mem_if.DataInA = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        sweep("reset_sweep");

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            mem_if.AddrA   = 3'(i);
            mem_if.WEA     = 1'b1;
            mem_if.DataInA = fill_v[i];
            @(posedge clk);
            model[i] = fill_v[i];
        end
        @(negedge clk);
        mem_if.WEA = 1'b0;
        sweep("fill_sweep");

        // Read-during-write on address 3: old word before the edge, new after.
        @(negedge clk);
        mem_if.AddrA   = 3'd3;
        mem_if.WEA     = 1'b1;
        mem_if.DataInA = 8'h5A;
        #1;
        expect_now("rdw_before", 8'hD7);
        @(posedge clk);
        model[3] = 8'h5A;
        #1;
        expect_now("rdw_after", 8'h5A);
        @(negedge clk);
        mem_if.WEA = 1'b0;
        sweep("rdw_others");

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            mem_if.AddrA   = 3'(i);
            mem_if.DataInA = 8'($urandom);
            #1;
            expect_now("hold", model[i]);
        end
        sweep("hold_sweep");

        write_word(3'd7, 8'hFF);
        write_word(3'd7, 8'h00);
        @(negedge clk);
        mem_if.AddrA = 3'd7;
        #1;
        expect_now("overwrite_a7", 8'h00);
        mem_if.AddrA = 3'd6;
        #1;
        expect_now("overwrite_a6", 8'h85);

        // Asynchronous reset between edges, then a write attempt while held in reset.
        @(negedge clk);
        mem_if.AddrA = 3'd2;
        #1;
        expect_now("pre_reset", 8'hB7);
        rst_n = 1'b0;
        #1;
        expect_now("async_clear", 8'h00);
        for (int i = 0; i < 8; i++) model[i] = 8'h00;
        write_word(3'd4, 8'h99);
        mem_if.AddrA = 3'd4;
        #1;
        expect_now("write_in_reset", 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        sweep("post_reset_sweep");

        write_word(3'd5, 8'h3C);
        mem_if.AddrA = 3'd5;
        #1;
        expect_now("first_write_after_reset", 8'h3C);

        #20;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/memory_a.md
# memory_a

8-entry × 8-bit register-file memory ("memory A") that serves as the source store in the memory-to-memory transfer path. It has one address port shared by reads and writes: a synchronous write strobe and a combinational read data output. Contents are loaded by the producer/testbench, then read out word by word by the transfer logic.

## Interface
- DATA_WIDTH, default 8: word width in bits.
- ADDR_WIDTH, default 3: address width; depth = 2**ADDR_WIDTH (8 words).
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- AddrA  input  ADDR_WIDTH  word address for both write and read.
- WEA  input  1  write enable, active high.
- DataInA  input  DATA_WIDTH  write data.
- DataOut  output  DATA_WIDTH  read data, always mem[AddrA].

## Operation
- Storage: array mem[0..DEPTH-1] of DATA_WIDTH-bit words, built from flops, not inferred RAM, because reset must clear it.
- Reset: rst_n low clears every word to 0 immediately, regardless of clk. DataOut therefore reads 0 while in reset and after release until a word is written.
- Write: on a rising clk edge with rst_n high and WEA=1, mem[AddrA] <= DataInA. Only the addressed word changes.
- Read: DataOut = mem[AddrA] combinationally, independent of WEA. There is no output register and no read enable.
- WEA=0: memory holds. DataOut follows AddrA changes within the same cycle.
- X/unknown WEA or AddrA: no requirement beyond simulation semantics. The bench drives known values before the first edge.
- Address range: every ADDR_WIDTH value is valid. There is no out-of-range case and no wrap logic.

## Timing
- Write latency: 1 edge. The data is visible on DataOut (same address) immediately after the capturing edge.
- Read-during-write, same address: before the edge DataOut shows the old word; after the edge it shows the new word. There is no write-through bypass.
- Back-to-back writes to different addresses on consecutive edges: each captured independently.
- Reset asserted mid-write: reset wins. The word is 0 after reset, and no write occurs on any edge while rst_n=0.
- Reset deasserted: the first write is on the first rising edge at which rst_n is high.
- Read path is purely combinational: AddrA → DataOut mux, one DEPTH:1 mux deep.

## Structure
- Shared package mem_xfer_pkg: DATA_WIDTH=8, ADDR_WIDTH=3, DEPTH=8 constants; data_t and addr_t typedefs. This package is reused by memory B and the transfer controller.
- memory_a: write-decode logic, register array with async clear, and read mux.
- Optional sub-module mem_word_reg: one DATA_WIDTH register with async clear and load enable, instantiated DEPTH times via generate. It is acceptable to flatten it into memory_a instead.

## Test plan
- Reset: pulse rst_n low, sweep AddrA 0..7 with WEA=0 → DataOut = 0x00 at every address.
- Fill: WEA=1, one word per edge: addr0=0x23, 1=0x87, 2=0xB7, 3=0xD7, 4=0x11, 5=0xC1, 6=0x85, 7=0x07. Then WEA=0, sweep 0..7 → DataOut returns exactly those values in order.
- Read-during-write: mem[3]=0xD7, drive AddrA=3, WEA=1, DataInA=0x5A → DataOut=0xD7 before the edge and 0x5A after it. All other addresses are unchanged.
- Hold: WEA=0 with DataInA toggling randomly for 8 cycles → no word changes.
- Async reset mid-operation: after the fill, drop rst_n between edges → DataOut goes to 0x00 without a clock edge. A write attempted while rst_n=0 is ignored.
- Overwrite: write 0xFF then 0x00 to addr 7 on consecutive edges → final read at addr 7 = 0x00, addr 6 = 0x85.
